// File: rtl/vend_credit_controller.sv
// ---------------------------------------------------------------------------
// vend_credit_controller
//
// Front end of the change-dispense path. It adds inserted coins to a credit
// register and rejects any coin that would push credit past MAX_CREDIT. It
// accepts a product selection and either releases the item or reports short
// funds. After a vend that leaves a remainder, or after a cancel, it offers a
// 9-bit change value on a valid/ack handshake.
//
// Parameters
//   PRICE0..PRICE3 : item prices in cents (each must be <= MAX_CREDIT)
//   MAX_CREDIT     : credit ceiling in cents (must be <= 399 so the
//                    downstream quarter count stays within 4 bits)
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   coin_valid   in   one-cycle coin strobe
//   coin_type    in   0 penny, 1 nickel, 2 dime, 3 quarter
//   sel_valid    in   one-cycle selection strobe
//   sel_item     in   selected item index
//   cancel       in   one-cycle refund request
//   change_ack   in   downstream has taken the change value
//   credit       out  accumulated credit in cents
//   coin_reject  out  one-cycle pulse, coin returned uncredited
//   short_funds  out  one-cycle pulse, selection refused for lack of credit
//   vend         out  one-cycle pulse, item released
//   vend_item    out  item index that accompanies vend
//   change       out  change amount, valid while change_valid
//   change_valid out  change offer pending
//   busy         out  high while vending or offering change
// ---------------------------------------------------------------------------
module vend_credit_controller #(
  parameter int PRICE0     = 65,
  parameter int PRICE1     = 100,
  parameter int PRICE2     = 125,
  parameter int PRICE3     = 150,
  parameter int MAX_CREDIT = 399
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       sel_valid,
  input  logic [1:0] sel_item,
  input  logic       cancel,
  input  logic       change_ack,
  output logic [8:0] credit,
  output logic       coin_reject,
  output logic       short_funds,
  output logic       vend,
  output logic [1:0] vend_item,
  output logic [8:0] change,
  output logic       change_valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CREDIT,
    ST_VEND,
    ST_CHANGE
  } state_t;

  // The sum is one bit wider than credit so that the ceiling test sees the
  // true total before anything is committed.
  localparam logic [9:0] MAX_CREDIT_W = 10'(MAX_CREDIT);
  localparam logic [8:0] PRICE0_W     = 9'(PRICE0);
  localparam logic [8:0] PRICE1_W     = 9'(PRICE1);
  localparam logic [8:0] PRICE2_W     = 9'(PRICE2);
  localparam logic [8:0] PRICE3_W     = 9'(PRICE3);

  state_t     state, state_nxt;
  logic [8:0] credit_nxt;
  logic [8:0] change_nxt;
  logic       change_valid_nxt;
  logic       coin_reject_nxt;
  logic       short_funds_nxt;
  logic       vend_nxt;
  logic [1:0] vend_item_nxt;

  logic [8:0] coin_value;
  logic [8:0] price;
  logic [9:0] coin_sum;
  logic [8:0] vend_diff;

  // Coin denomination in cents.
  always_comb begin
    coin_value = 9'd1;
    case (coin_type)
      2'd0:    coin_value = 9'd1;
      2'd1:    coin_value = 9'd5;
      2'd2:    coin_value = 9'd10;
      default: coin_value = 9'd25;
    endcase
  end

  // Price of the item being selected this cycle.
  always_comb begin
    price = PRICE0_W;
    case (sel_item)
      2'd0:    price = PRICE0_W;
      2'd1:    price = PRICE1_W;
      2'd2:    price = PRICE2_W;
      default: price = PRICE3_W;
    endcase
  end

  // vend_diff is used only when credit >= price, so it never wraps.
  assign coin_sum  = {1'b0, credit} + {1'b0, coin_value};
  assign vend_diff = credit - price;

  // Next-state and next-output logic. While credit can be spent, cancel wins
  // over a selection, and a selection wins over a coin. A coin that arrives
  // alongside either of them is always handed back.
  always_comb begin
    state_nxt        = state;
    credit_nxt       = credit;
    change_nxt       = change;
    change_valid_nxt = change_valid;
    coin_reject_nxt  = 1'b0;
    short_funds_nxt  = 1'b0;
    vend_nxt         = 1'b0;
    vend_item_nxt    = vend_item;

    case (state)
      ST_IDLE, ST_CREDIT: begin
        if (cancel) begin
          coin_reject_nxt = coin_valid;
          if (credit != 9'd0) begin
            change_nxt       = credit;
            change_valid_nxt = 1'b1;
            credit_nxt       = 9'd0;
            state_nxt        = ST_CHANGE;
          end
        end else if (sel_valid) begin
          coin_reject_nxt = coin_valid;
          if (credit >= price) begin
            vend_nxt      = 1'b1;
            vend_item_nxt = sel_item;
            credit_nxt    = 9'd0;
            state_nxt     = ST_VEND;
            if (vend_diff != 9'd0) begin
              change_nxt       = vend_diff;
              change_valid_nxt = 1'b1;
            end
          end else begin
            short_funds_nxt = 1'b1;
          end
        end else if (coin_valid) begin
          if (coin_sum <= MAX_CREDIT_W) begin
            credit_nxt = coin_sum[8:0];
            state_nxt  = ST_CREDIT;
          end else begin
            coin_reject_nxt = 1'b1;
          end
        end
      end

      // One cycle to release the item. Credit is already zero, so the
      // machine goes to the change handshake if change is owed, else to idle.
      ST_VEND: begin
        coin_reject_nxt = coin_valid;
        state_nxt       = change_valid ? ST_CHANGE : ST_IDLE;
      end

      // Hold the change offer until the downstream stage takes it.
      ST_CHANGE: begin
        coin_reject_nxt = coin_valid;
        if (change_ack) begin
          change_valid_nxt = 1'b0;
          change_nxt       = 9'd0;
          state_nxt        = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers. Reset clears any credit and any pending
  // change straight away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      credit       <= 9'd0;
      change       <= 9'd0;
      change_valid <= 1'b0;
      coin_reject  <= 1'b0;
      short_funds  <= 1'b0;
      vend         <= 1'b0;
      vend_item    <= 2'd0;
    end else begin
      state        <= state_nxt;
      credit       <= credit_nxt;
      change       <= change_nxt;
      change_valid <= change_valid_nxt;
      coin_reject  <= coin_reject_nxt;
      short_funds  <= short_funds_nxt;
      vend         <= vend_nxt;
      vend_item    <= vend_item_nxt;
    end
  end

  assign busy = (state == ST_VEND) || (state == ST_CHANGE);

endmodule

// File: tb/tb_vend_credit_controller.sv
// ---------------------------------------------------------------------------
// tb_vend_credit_controller
//
// Scoreboard bench. Each stimulus cycle goes through a cents-level model of
// the vending rules. The model queues every output event it expects for the
// next cycle. An independent monitor watches the DUT on the falling edge and
// matches each observed event against the queue. It reports unexpected
// events and events that never appeared.
// ---------------------------------------------------------------------------
module tb_vend_credit_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_type = 2'd0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_item = 2'd0;
  logic       cancel = 1'b0;
  logic       change_ack = 1'b0;
  logic [8:0] credit;
  logic       coin_reject;
  logic       short_funds;
  logic       vend;
  logic [1:0] vend_item;
  logic [8:0] change;
  logic       change_valid;
  logic       busy;

  vend_credit_controller dut (
    .clk          (clk),
    .rst          (rst),
    .coin_valid   (coin_valid),
    .coin_type    (coin_type),
    .sel_valid    (sel_valid),
    .sel_item     (sel_item),
    .cancel       (cancel),
    .change_ack   (change_ack),
    .credit       (credit),
    .coin_reject  (coin_reject),
    .short_funds  (short_funds),
    .vend         (vend),
    .vend_item    (vend_item),
    .change       (change),
    .change_valid (change_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int K_REJ = 0, K_SHORT = 1, K_VEND = 2, K_CHG = 3,
                 K_DONE = 4, K_CREDIT = 5, K_BUSY = 6;

  typedef struct {
    int kind;
    int val;
    int due;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state, in plain cents.
  int   prices[4] = '{65, 100, 125, 150};
  int   coins[4]  = '{1, 5, 10, 25};
  int   m_credit = 0;
  int   m_owed   = 0;
  int   m_phase  = 0;   // 0 ready for money, 1 releasing item, 2 owing change
  bit   m_busy   = 1'b0;

  function automatic string kname(input int k);
    case (k)
      K_REJ:    return "coin_reject";
      K_SHORT:  return "short_funds";
      K_VEND:   return "vend_item";
      K_CHG:    return "change_offer";
      K_DONE:   return "change_done";
      K_CREDIT: return "credit";
      default:  return "busy";
    endcase
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic pushExp(input int kind, input int val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.due  = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic popExpect(input int kind, input int actual);
    int idx = -1;
    foreach (exp_q[i])
      if (idx < 0 && exp_q[i].kind == kind && exp_q[i].due == cyc) idx = i;
    if (idx < 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL unexpected %s at cycle %0d: got %0d, expected no event", kname(kind), cyc, actual);
    end else begin
      checkOutput(kname(kind), actual, exp_q[idx].val);
      exp_q.delete(idx);
    end
  endtask

  task automatic modelReset();
    m_credit = 0;
    m_owed   = 0;
    m_phase  = 0;
    m_busy   = 1'b0;
    exp_q.delete();
  endtask

  // Applies the machine's rules to one cycle of inputs. It queues what should
  // become visible on the following cycle.
  task automatic modelStep(input bit cv, input int ct, input bit sv, input int si,
                           input bit cn, input bit ack);
    int old_credit = m_credit;
    bit old_busy   = m_busy;
    bit rej = 0, sh = 0, vd = 0, rise = 0, done = 0;
    case (m_phase)
      1: begin
        rej     = cv;
        m_phase = (m_owed > 0) ? 2 : 0;
      end
      2: begin
        rej = cv;
        if (ack) begin
          done    = 1;
          m_owed  = 0;
          m_phase = 0;
        end
      end
      default: begin
        if (cn) begin
          rej = cv;
          if (m_credit > 0) begin
            m_owed   = m_credit;
            m_credit = 0;
            rise     = 1;
            m_phase  = 2;
          end
        end else if (sv) begin
          rej = cv;
          if (m_credit >= prices[si]) begin
            vd       = 1;
            m_owed   = m_credit - prices[si];
            m_credit = 0;
            rise     = (m_owed > 0);
            m_phase  = 1;
          end else begin
            sh = 1;
          end
        end else if (cv) begin
          if (m_credit + coins[ct] <= 399) m_credit = m_credit + coins[ct];
          else rej = 1;
        end
      end
    endcase
    m_busy = (m_phase != 0);
    if (rej)  pushExp(K_REJ, 1);
    if (sh)   pushExp(K_SHORT, 1);
    if (vd)   pushExp(K_VEND, si);
    if (rise) pushExp(K_CHG, m_owed);
    if (done) pushExp(K_DONE, 0);
    if (m_credit != old_credit) pushExp(K_CREDIT, m_credit);
    if (m_busy != old_busy) pushExp(K_BUSY, int'(m_busy));
  endtask

  // Drives one cycle of inputs, which hold until the next call, and updates
  // the model.
  task automatic applyStimulus(input bit cv, input int ct, input bit sv, input int si,
                               input bit cn, input bit ack);
    @(posedge clk);
    #1;
    coin_valid = cv;
    coin_type  = 2'(ct);
    sel_valid  = sv;
    sel_item   = 2'(si);
    cancel     = cn;
    change_ack = ack;
    modelStep(cv, ct, sv, si, cn, ack);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic coin(input int ct);
    applyStimulus(1, ct, 0, 0, 0, 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_credit"}, int'(credit), 0);
    checkOutput({tag, "_change"}, int'(change), 0);
    checkOutput({tag, "_change_valid"}, int'(change_valid), 0);
    checkOutput({tag, "_vend"}, int'(vend), 0);
    checkOutput({tag, "_vend_item"}, int'(vend_item), 0);
    checkOutput({tag, "_coin_reject"}, int'(coin_reject), 0);
    checkOutput({tag, "_short_funds"}, int'(short_funds), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
  endtask

  // Asserts reset between clock edges and checks that the outputs clear
  // before any edge arrives.
  task automatic doReset();
    @(posedge clk);
    #3;
    coin_valid = 0; sel_valid = 0; cancel = 0; change_ack = 0;
    rst = 1'b1;
    #1;
    checkAllZero("async_reset");
    modelReset();
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Monitor: matches every observable DUT event against the scoreboard.
  initial begin
    logic [8:0] prev_credit = 0;
    logic [8:0] prev_change = 0;
    logic       prev_cv = 0;
    logic       prev_busy = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_credit = 0; prev_change = 0; prev_cv = 0; prev_busy = 0;
      end else begin
        if (coin_reject) popExpect(K_REJ, 1);
        if (short_funds) popExpect(K_SHORT, 1);
        if (vend) popExpect(K_VEND, int'(vend_item));
        if (change_valid && !prev_cv) popExpect(K_CHG, int'(change));
        if (!change_valid && prev_cv) begin
          popExpect(K_DONE, 0);
          checkOutput("change_cleared", int'(change), 0);
        end
        if (change_valid && prev_cv) checkOutput("change_stable", int'(change), int'(prev_change));
        if (credit != prev_credit) popExpect(K_CREDIT, int'(credit));
        if (busy != prev_busy) popExpect(K_BUSY, int'(busy));
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          tests++;
          fails++;
          $display("[TB] FAIL missing %s at cycle %0d: got no event, expected %0d",
                   kname(exp_q[0].kind), cyc, exp_q[0].val);
          void'(exp_q.pop_front());
        end
        prev_credit = credit; prev_change = change; prev_cv = change_valid; prev_busy = busy;
      end
    end
  end

  initial begin
    $display("[TB] start");
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checkAllZero("reset");
    @(negedge clk);
    #2;
    rst = 1'b0;

    // Accumulate 85 cents.
    coin(3); coin(3); coin(3); coin(2);
    idle(1);
    // Funded vend of item 0 leaves 20 cents of change, held until acked.
    applyStimulus(0, 0, 1, 0, 0, 0);
    idle(5);
    applyStimulus(0, 0, 0, 0, 0, 1);
    idle(2);

    // Exact vend of item 1.
    repeat (4) coin(3);
    applyStimulus(0, 0, 1, 1, 0, 0);
    idle(2);

    // Short funds for item 2 at 50 cents, then cancel and collect.
    coin(3); coin(3);
    applyStimulus(0, 0, 1, 2, 0, 0);
    idle(1);
    applyStimulus(0, 0, 0, 0, 1, 0);
    idle(1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    idle(1);

    // Ceiling: 390, then quarter rejected, nickel, pennies up to 399.
    repeat (15) coin(3);
    coin(2); coin(1);
    coin(3);
    coin(1);
    repeat (4) coin(0);
    coin(0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    idle(1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    idle(1);

    // Cancel, select and quarter together at 60 cents.
    coin(3); coin(3); coin(2);
    applyStimulus(1, 3, 1, 0, 1, 0);
    idle(1);
    coin(2);
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    idle(1);

    // Reset while 20 cents of change is pending.
    coin(3); coin(3); coin(3); coin(2);
    applyStimulus(0, 0, 1, 0, 0, 0);
    idle(1);
    checkOutput("pre_reset_change_valid", int'(change_valid), 1);
    checkOutput("pre_reset_change", int'(change), 20);
    doReset();
    coin(3);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit cv  = ($urandom_range(0, 9) < 4);
      bit sv  = ($urandom_range(0, 9) == 0);
      bit cn  = ($urandom_range(0, 19) == 0);
      bit ack = ($urandom_range(0, 3) == 0);
      applyStimulus(cv, int'($urandom_range(0, 3)), sv, int'($urandom_range(0, 3)), cn, ack);
    end
    idle(2);
    repeat (10) applyStimulus(0, 0, 0, 0, 0, 1);
    idle(3);
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vend_credit_controller.md
# vend_credit_controller

Upstream stage of the change-dispense path. Accumulates inserted coins into a credit register, accepts a product selection, and on a successful vend or a cancel produces a 9-bit `change` value with a valid/ack handshake. `change` connects directly to the combinational change-to-coin-count breakdown stage. It also rejects coins that would overflow the credit limit, and signals selections that lack sufficient funds.

## Interface
- `PRICE0`, 65: price of item 0 in cents
- `PRICE1`, 100: price of item 1
- `PRICE2`, 125: price of item 2
- `PRICE3`, 150: price of item 3
- `MAX_CREDIT`, 399: credit ceiling in cents. Must be ≤ 399 so the downstream 4-bit quarter count cannot overflow. Every PRICEn must be ≤ MAX_CREDIT.

- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `coin_valid` in 1: one-cycle coin-inserted strobe
- `coin_type` in 2: 0 = penny (1), 1 = nickel (5), 2 = dime (10), 3 = quarter (25)
- `sel_valid` in 1: one-cycle selection strobe
- `sel_item` in 2: selected item index
- `cancel` in 1: one-cycle refund request
- `change_ack` in 1: downstream has taken `change`
- `credit` out 9: current accumulated credit
- `coin_reject` out 1: one-cycle pulse, coin returned and not credited
- `short_funds` out 1: one-cycle pulse, selection refused for lack of credit
- `vend` out 1: one-cycle pulse, item released
- `vend_item` out 2: item index, valid with `vend`
- `change` out 9: change amount, valid while `change_valid`
- `change_valid` out 1: change offer pending
- `busy` out 1: high in VEND or CHANGE

## Operation
- **States:** IDLE (credit = 0), CREDIT (credit > 0), VEND, CHANGE.
- **Reset:** state IDLE. All outputs are 0: `credit`, `change`, `vend_item`, and every pulse and valid. Reset mid-transaction discards credit and any pending change.
- **Event priority per cycle in IDLE/CREDIT:** cancel, then selection, then coin.
- **Coin, no sel/cancel in the same cycle:**
  - If credit + value ≤ MAX_CREDIT: credit += value, and state is CREDIT.
  - Otherwise: `coin_reject` pulses and credit is unchanged.
- **Coin coincident with sel or cancel:** always rejected, with a `coin_reject` pulse.
- **Selection:** price = PRICE[`sel_item`].
  - If credit ≥ price: go to VEND. `vend` pulses and `vend_item` = `sel_item`. diff = credit − price, and credit clears to 0.
  - If diff > 0: `change` = diff, `change_valid` = 1, and the VEND state is left for CHANGE.
  - If diff = 0: return to IDLE.
  - If credit < price: `short_funds` pulses. Credit and state are unchanged.
- **Cancel:**
  - If credit > 0: `change` = credit, `change_valid` = 1, credit = 0, go to CHANGE with no vend.
  - If credit = 0: ignored.
- **CHANGE:**
  - `change_valid` and `change` are held stable until `change_ack` is sampled high.
  - On ack: next cycle `change_valid` = 0, `change` = 0, state IDLE.
  - Coins are rejected (`coin_reject`). Selection and cancel are ignored.
- **`change_ack` outside CHANGE:** ignored.
- **Arithmetic:** 9-bit unsigned throughout. Overflow is impossible given the MAX_CREDIT constraint.

## Timing
- All outputs are registered.
- **Coin strobe at cycle N:**
  - `credit` shows the new value at N+1.
  - `coin_reject`, if any, is high at N+1 only.
- **Selection at cycle N (funded):**
  - `vend`, `vend_item`, `credit` = 0, `busy` = 1, and (if diff > 0) `change`/`change_valid` are all present at N+1.
  - `vend` lasts exactly one cycle.
  - With diff = 0, `busy` drops at N+2.
- **Selection at cycle N (underfunded):** `short_funds` is high at N+1 only.
- **Cancel at cycle N:** `change_valid` rises at N+1.
- **`change_ack` sampled at cycle M:** `change_valid` falls at M+1, and a coin is accepted at M+1 at the earliest.
- **Minimum spacing:** two transactions are at least 3 cycles apart (select, vend, ack).
- **Asynchronous reset:** takes effect immediately, without waiting for a clock edge.

## Test plan
- **Reset and accumulate:** reset, then quarter ×3 and dime ×1 → `credit` = 85 one cycle after each strobe. No pulses.
- **Funded vend with change:** credit 85, select item 0 → `vend` = 1 and `vend_item` = 0 for one cycle, `change` = 20, `change_valid` = 1 held over 5 wait cycles. Then `change_ack` → `change_valid` = 0 next cycle, state IDLE.
- **Exact vend and short funds:**
  - Credit 100, select item 1 → `vend` pulse, `change_valid` stays 0, `credit` = 0.
  - Credit 50, select item 2 → `short_funds` pulse, `credit` remains 50.
- **Overflow reject:** credit 390, insert a quarter → `coin_reject` pulse, `credit` = 390. Insert a nickel → `credit` = 395. Insert 4 pennies → 399. Insert a 5th penny → rejected.
- **Simultaneous events:**
  - Credit 60: cancel + sel + quarter in the same cycle → `change` = 60, `coin_reject` pulse, no `vend`.
  - During CHANGE: a coin → `coin_reject`; a select → ignored.
- **Reset mid-operation:** assert `rst` while `change_valid` = 1 with `change` = 20 → all outputs 0 immediately. After release, a quarter gives `credit` = 25.
